// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU arbiter: datapath width,
// ALU opcodes and the arbiter FSM encoding.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: add/sub/and/or/xor/signed slt.
// Opcodes 110/111 are undefined and return zero.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = a + b;
      ALU_SUB: alu_result = a - b;
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_XOR: alu_result = a ^ b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker: first valid requester at or after ptr,
// wrapping modulo NREQ. Grant is one-hot, or zero when nothing is valid.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);

  int  j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU among NREQ requesters, round-robin, one operation
// in flight; results come back registered and tagged with the requester id.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | offering a grant to the round-robin winner
//   ST_EXEC | ALU evaluating latched operands; result captured at edge
//   ST_RESP | result presented, waiting for rsp_ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*3-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_illegal,
  output logic                 busy
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, pick_idx, id_q;
  logic [NREQ-1:0] pick_grant;
  logic [XLEN-1:0] a_q, b_q, alu_result;
  logic [2:0]      op_q;
  logic            alu_zero;
  logic            handshake;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Driven only from latched operands so live buses cannot disturb EXEC.
  alu u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .alu_result  (alu_result),
    .zero        (alu_zero)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (!rst) req_ready = pick_grant;
        if (|req_ready) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign handshake = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_id      <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      if (state == ST_IDLE && handshake) begin
        a_q    <= req_a[int'(pick_idx)*XLEN +: XLEN];
        b_q    <= req_b[int'(pick_idx)*XLEN +: XLEN];
        op_q   <= req_op[int'(pick_idx)*3 +: 3];
        id_q   <= pick_idx;
        rr_ptr <= (pick_idx == ID_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == ST_EXEC) begin
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_illegal <= (op_q >= 3'b110);
        rsp_id      <= id_q;
        rsp_valid   <= 1'b1;
      end
      if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_op;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_illegal, busy;
  logic [ID_W-1:0]   rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // First valid requester scanning upward from ptr with wraparound; -1 if none.
  function automatic int winner_ref(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Reference model: phase 0 = free, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  logic [31:0] m_res   = '0;
  logic [2:0]  m_op    = '0;
  int          m_w;
  logic [NREQ-1:0] m_rdy;
  int          obs[$];

  always @(negedge clk) begin
    m_w   = (!rst && m_phase == 0) ? winner_ref(req_valid, m_ptr) : -1;
    m_rdy = '0;
    if (m_w >= 0) m_rdy[m_w] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(m_rdy));
    check_val("busy", 32'(busy), 32'(m_phase != 0));
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check_val("rsp_result", rsp_result, m_res);
      check_val("rsp_zero", 32'(rsp_zero), 32'(m_res == 0));
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
      check_val("rsp_illegal", 32'(rsp_illegal), 32'(m_op >= 3'd6));
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && req_valid[i]) obs.push_back(i);
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: if (m_w >= 0) begin
             m_op    = req_op[3*m_w +: 3];
             m_res   = alu_ref(req_a[32*m_w +: 32], req_b[32*m_w +: 32], m_op);
             m_id    = m_w;
             m_ptr   = (m_w + 1) % NREQ;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_valid[i]     = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NREQ; i++) clr_req(i);
  endtask

  task automatic run_one(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] er, input logic ez, input logic ei);
    rsp_ready = 1'b1;
    set_req(i, a, b, op);
    cyc(1);
    clr_req(i);
    check_val({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    cyc(1);
    check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_val({tag, "_result"}, rsp_result, er);
    check_val({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
    check_val({tag, "_id"}, 32'(rsp_id), 32'(i));
    check_val({tag, "_illegal"}, 32'(rsp_illegal), 32'(ei));
    cyc(1);
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    check_val({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < obs.size(); k++)
      check_val(tag, 32'(obs[k]), 32'(exp[k]));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [NREQ-1:0] hs;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    set_req(0, 32'd5, 32'd3, 3'd0);
    cyc(2);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_result", rsp_result, 32'd0);
    check_val("rst_zero", 32'(rsp_zero), 32'd0);
    check_val("rst_id", 32'(rsp_id), 32'd0);
    check_val("rst_illegal", 32'(rsp_illegal), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);

    // reset while req0 is executing
    rst = 1'b0;
    cyc(1);
    clr_req(0);
    check_val("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_val("midrst_valid", 32'(rsp_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    cyc(3);
    check_val("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // all four valid continuously: pointer must restart at 0 after reset
    obs.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 10), 32'd3, 3'(i));
    cyc(13);
    clr_all();
    cyc(3);
    check_order("rr_order", '{0, 1, 2, 3, 0});

    // late-rising requester 3 is served before the pointer wraps to 0
    obs.delete();
    for (int i = 0; i < 3; i++) set_req(i, 32'(i), 32'd1, 3'd0);
    cyc(1);
    set_req(3, 32'd7, 32'd7, 3'd4);
    cyc(10);
    clr_all();
    cyc(3);
    check_order("late_order", '{1, 2, 3, 0});

    // backpressure with a competing requester waiting
    rsp_ready = 1'b0;
    set_req(1, 32'h0000_F0F0, 32'h0000_0FF0, 3'd2);
    cyc(1);
    clr_req(1);
    set_req(2, 32'd1, 32'd2, 3'd0);
    cyc(1);
    check_val("bp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check_val("bp_result", rsp_result, 32'h0000_00F0);
      check_val("bp_id", 32'(rsp_id), 32'd1);
      check_val("bp_ready", 32'(req_ready), 32'd0);
      check_val("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    cyc(1);
    check_val("bp_idle_busy", 32'(busy), 32'd0);
    check_val("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check_val("bp_next_grant", 32'(req_ready), 32'b0100);
    cyc(1);
    clr_req(2);
    check_val("bp_regrant_busy", 32'(busy), 32'd1);
    cyc(2);

    // withdrawn request is never granted
    obs.delete();
    rsp_ready = 1'b0;
    set_req(3, 32'd2, 32'd2, 3'd1);
    cyc(1);
    clr_req(3);
    set_req(0, 32'd9, 32'd9, 3'd0);
    cyc(3);
    clr_req(0);
    rsp_ready = 1'b1;
    cyc(3);
    check_order("withdraw", '{3});
    check_val("withdraw_valid", 32'(rsp_valid), 32'd0);

    run_one("add", 1, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_one("sub", 2, 32'd9, 32'd9, 3'd1, 32'd0, 1'b1, 1'b0);
    run_one("slt", 2, 32'hFFFF_FFFF, 32'd1, 3'd5, 32'd1, 1'b0, 1'b0);
    run_one("ill", 3, 32'd4, 32'd4, 3'd7, 32'd0, 1'b1, 1'b1);

    // randomized protocol-compliant traffic
    obs.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_ready & req_valid;
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
          else clr_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          clr_req(i);
        end
      end
      if (obs.size() > 64) obs.delete();
    end
    rst = 1'b0;
    clr_all();
    rsp_ready = 1'b1;
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
